cfu_cmd_sequencer: RTL and testbench

//  CFU command front-end; sits between the CPU CFU port and the vector decoder block.

---
 rtl/cfu_cmd_sequencer.sv | 69 ++++++
 tb/tb_cfu_cmd_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cfu_cmd_sequencer.sv
// cfu_cmd_sequencer: CFU command front-end that issues to the decoder, sequences latency, owns vl and returns responses
module cfu_cmd_sequencer #(
  parameter int VLMAX = 16,
  parameter int MUL_LAT = 3,
  parameter int VLW = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [9:0]     cmd_payload_function_id,
  input  logic [31:0]    cmd_payload_inputs_0,
  input  logic [31:0]    cmd_payload_inputs_1,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [31:0]    rsp_payload_outputs_0,
  output logic           dec_valid,
  output logic [9:0]     dec_function_id,
  output logic [31:0]    dec_inputs_0,
  output logic [31:0]    dec_inputs_1,
  input  logic [31:0]    exec_result,
  output logic [VLW-1:0] vl
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [VLW:0] cnt;
  logic [2:0] f3;
  logic [VLW-1:0] vl_new;
  assign f3 = dec_function_id[2:0];
  assign vl_new = dec_inputs_0 > 32'(VLMAX) ? VLW'(VLMAX) : dec_inputs_0[VLW-1:0];
  assign cmd_ready = state == IDLE && !reset;
  assign rsp_valid = state == RESP;
  assign dec_valid = state == ISSUE && f3 != 3'd0 && f3 < 3'd6;
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (cmd_valid ? ISSUE : IDLE) :
              state == ISSUE ? ((f3 == 3'd0 || f3 > 3'd5) ? RESP : WAIT) :
              state == WAIT  ? (cnt == (VLW+1)'(1) ? RESP : WAIT) :
                               (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      vl <= '0;
      rsp_payload_outputs_0 <= '0;
      dec_function_id <= '0;
      dec_inputs_0 <= '0;
      dec_inputs_1 <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && cmd_valid) begin
        dec_function_id <= cmd_payload_function_id;
        dec_inputs_0 <= cmd_payload_inputs_0;
        dec_inputs_1 <= cmd_payload_inputs_1;
      end
      if (state == ISSUE) begin
        cnt <= f3 == 3'd4 ? (VLW+1)'(MUL_LAT) :
               (f3 == 3'd3 && vl != '0) ? {1'b0, vl} : (VLW+1)'(1);
        rsp_payload_outputs_0 <= f3 == 3'd0 ? 32'(vl_new) : '0;
        if (f3 == 3'd0) vl <= vl_new;
      end
      if (state == WAIT) begin
        cnt <= cnt - (VLW+1)'(1);
        if (cnt == (VLW+1)'(1)) rsp_payload_outputs_0 <= exec_result;
      end
    end
  end
endmodule

// File: tb/tb_cfu_cmd_sequencer.sv
// tb_cfu_cmd_sequencer: randomized and directed self-checking bench against a transaction-level model
module tb_cfu_cmd_sequencer;
  localparam int VLMAX = 16;
  localparam int MUL_LAT = 3;
  logic clk = 0;
  logic reset = 1;
  logic cmd_valid = 0;
  logic cmd_ready;
  logic [9:0] cmd_payload_function_id = '0;
  logic [31:0] cmd_payload_inputs_0 = '0;
  logic [31:0] cmd_payload_inputs_1 = '0;
  logic rsp_valid;
  logic rsp_ready = 0;
  logic [31:0] rsp_payload_outputs_0;
  logic dec_valid;
  logic [9:0] dec_function_id;
  logic [31:0] dec_inputs_0;
  logic [31:0] dec_inputs_1;
  logic [31:0] exec_result = '0;
  logic [4:0] vl;
  int passed = 0;
  int total = 0;
  int cyc = 0;
  bit busy = 0;
  bit is_dec = 0;
  int t0 = 0;
  int rsp_edge = 0;
  int m_vl = 0;
  logic [31:0] nvl = '0;
  logic [31:0] m_data = '0;
  logic [9:0] m_fid = '0;
  logic [31:0] m_in0 = '0;
  logic [31:0] m_in1 = '0;
  always #5 clk = ~clk;
  cfu_cmd_sequencer dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0),
    .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .dec_valid(dec_valid),
    .dec_function_id(dec_function_id),
    .dec_inputs_0(dec_inputs_0),
    .dec_inputs_1(dec_inputs_1),
    .exec_result(exec_result),
    .vl(vl)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
  endtask
  task automatic model_step();
    int lat;
    logic [2:0] f;
    if (reset) begin
      busy = 0;
      m_vl = 0;
      m_fid = '0;
      m_in0 = '0;
      m_in1 = '0;
    end else if (!busy) begin
      if (cmd_valid) begin
        busy = 1;
        t0 = cyc;
        m_fid = cmd_payload_function_id;
        m_in0 = cmd_payload_inputs_0;
        m_in1 = cmd_payload_inputs_1;
        f = cmd_payload_function_id[2:0];
        is_dec = f >= 3'd1 && f <= 3'd5;
        lat = f == 3'd4 ? MUL_LAT : f == 3'd3 ? (m_vl == 0 ? 1 : m_vl) : 1;
        nvl = cmd_payload_inputs_0 > 32'(VLMAX) ? 32'(VLMAX) : cmd_payload_inputs_0;
        m_data = f == 3'd0 ? nvl : '0;
        rsp_edge = is_dec ? t0 + 1 + lat : t0 + 1;
      end
    end else if (cyc - 1 >= rsp_edge) begin
      if (rsp_ready) busy = 0;
    end else begin
      if (is_dec && cyc == rsp_edge) m_data = exec_result;
      if (m_fid[2:0] == 3'd0 && cyc == t0 + 1) m_vl = int'(nvl);
    end
    cyc++;
  endtask
  task automatic compare();
    int e;
    bit exp_rv;
    e = cyc - 1;
    exp_rv = busy && e >= rsp_edge;
    chk("cmd_ready", 32'(cmd_ready), 32'(!busy && !reset));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("dec_valid", 32'(dec_valid), 32'(busy && is_dec && e == t0));
    chk("vl", 32'(vl), 32'(m_vl));
    chk("dec_function_id", 32'(dec_function_id), 32'(m_fid));
    chk("dec_inputs_0", dec_inputs_0, m_in0);
    chk("dec_inputs_1", dec_inputs_1, m_in1);
    if (exp_rv) chk("rsp_data", rsp_payload_outputs_0, m_data);
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask
  task automatic directed(input string name, input logic [9:0] fid, input logic [31:0] a,
                          input logic [31:0] ex, input int exp_n, input logic [31:0] exp_d,
                          input int exp_vl, input int exp_dec);
    int n;
    int dv;
    cmd_valid = 1;
    cmd_payload_function_id = fid;
    cmd_payload_inputs_0 = a;
    cmd_payload_inputs_1 = 32'hA5A5_0000 ^ a;
    exec_result = ex;
    rsp_ready = 1;
    tick();
    cmd_valid = 0;
    n = 1;
    dv = int'(dec_valid);
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
      dv += int'(dec_valid);
    end
    chk({name, "_latency"}, 32'(n), 32'(exp_n));
    chk({name, "_data"}, rsp_payload_outputs_0, exp_d);
    chk({name, "_vl"}, 32'(vl), 32'(exp_vl));
    chk({name, "_dec_pulses"}, 32'(dv), 32'(exp_dec));
    tick();
  endtask
  initial begin
    int n;
    repeat (3) tick();
    reset = 0;
    tick();
    directed("vsetvli5", 10'h000, 32'd5, 32'h0, 2, 32'd5, 5, 0);
    directed("vsetvli100", 10'h000, 32'd100, 32'h0, 2, 32'd16, 16, 0);
    directed("vadd", 10'h01A, 32'h1111, 32'hDEADBEEF, 3, 32'hDEADBEEF, 16, 1);
    chk("vadd_fid_held", 32'(dec_function_id), 32'h01A);
    directed("vmul", 10'h004, 32'h7, 32'hCAFE0001, 5, 32'hCAFE0001, 16, 1);
    directed("vsetvli5b", 10'h000, 32'd5, 32'h0, 2, 32'd5, 5, 0);
    directed("vacc5", 10'h00B, 32'h3, 32'h0BADF00D, 7, 32'h0BADF00D, 5, 1);
    directed("vsetvli0", 10'h000, 32'd0, 32'h0, 2, 32'd0, 0, 0);
    directed("vacc0", 10'h003, 32'h3, 32'h00C0FFEE, 3, 32'h00C0FFEE, 0, 1);
    directed("vsetvli_big", 10'h000, 32'hFFFF_FFF0, 32'h0, 2, 32'd16, 16, 0);
    directed("unknown7", 10'h0FF, 32'h55, 32'h12345678, 2, 32'h0, 16, 0);
    rsp_ready = 0;
    cmd_valid = 1;
    cmd_payload_function_id = 10'h00A;
    cmd_payload_inputs_0 = 32'h9;
    exec_result = 32'h12345678;
    tick();
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    repeat (4) begin
      tick();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rsp_payload_outputs_0, 32'h12345678);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1;
    tick();
    chk("bp_idle_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("bp_second_issue", 32'(dec_valid), 32'd1);
    cmd_valid = 0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    tick();
    directed("vsetvli9", 10'h000, 32'd9, 32'h0, 2, 32'd9, 9, 0);
    cmd_valid = 1;
    cmd_payload_function_id = 10'h02C;
    cmd_payload_inputs_0 = 32'hABCD;
    tick();
    cmd_valid = 0;
    tick();
    tick();
    reset = 1;
    tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_vl", 32'(vl), 32'd0);
    chk("rst_dec_fid", 32'(dec_function_id), 32'd0);
    chk("rst_dec_in0", dec_inputs_0, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    reset = 0;
    tick();
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    repeat (3000) begin
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_payload_function_id = 10'($urandom);
      cmd_payload_inputs_0 = $urandom_range(0, 2) == 0 ? $urandom : $urandom_range(0, 24);
      cmd_payload_inputs_1 = $urandom;
      rsp_ready = $urandom_range(0, 9) < 7;
      exec_result = $urandom;
      reset = $urandom_range(0, 199) == 0;
      tick();
    end
    reset = 0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
